gate_response_checker: RTL and testbench
========================================

GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 4: samples checked per run (1..255).
REQ-002 SHALL have parameter ERR_W, default 8: error-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins/restarts a run.
REQ-006 SHALL have port sample_valid  input  1  a, b, y_* valid this cycle.
REQ-007 SHALL have ports a, b  input  1 each  stimulus applied to the gates under test.
REQ-008 SHALL have port y  input  7  observed outputs {xnor,xor,nor,nand,not,or,and}, bit0 = and.
REQ-009 SHALL have port busy  output  1  run in progress.
REQ-010 SHALL have port done  output  1  run finished (level).
REQ-011 SHALL have port pass  output  1  done, zero errors, all four a/b combinations covered.
REQ-012 SHALL have port err_count  output  ERR_W  mismatching samples, saturating.
REQ-013 SHALL have port err_mask  output  7  sticky per-gate failure flags.
REQ-014 SHALL have port coverage  output  4  sticky seen flags, bit index = {a,b}.

Function
REQ-015 SHALL implement FSM IDLE -> CHECK on start; CHECK -> DONE when accepted-sample count reaches NUM_VECTORS; DONE -> CHECK on start.
REQ-016 SHALL, on start in any state, clear err_count, err_mask, coverage and sample count, and enter CHECK next cycle.
REQ-017 SHALL accept a sample only when sample_valid=1, state=CHECK, and start=0; start wins when both are high, and that sample is discarded.
REQ-018 SHALL ignore sample_valid in IDLE and DONE.
REQ-019 SHALL compute expected = {~(a^b), a^b, ~(a|b), ~(a&b), ~a, a|b, a&b} combinationally and compare it with y in the acceptance cycle.
REQ-020 SHALL update registers on the edge ending the acceptance cycle: err_mask |= (y ^ expected); coverage[{a,b}] = 1; err_count +1 if any bit mismatches, holding at all-ones.
REQ-021 SHALL enter DONE on the same edge that accepts sample NUM_VECTORS; done and pass are valid from the following cycle.
REQ-022 SHALL drive busy=1 only in CHECK, done=1 only in DONE, pass = done & (err_count==0) & (coverage==4'hF).
REQ-023 SHALL hold all result outputs stable in DONE until the next start or reset.
REQ-024 SHALL report pass=0 when NUM_VECTORS<4 prevents full coverage; this is not an error condition.

Reset
REQ-025 SHALL, on rst=1, immediately enter IDLE with busy=0, done=0, pass=0, err_count=0, err_mask=0, coverage=0 and sample count=0, regardless of clock.
REQ-026 SHALL abandon a run on reset mid-CHECK; no partial result survives.
REQ-027 SHALL ignore start while rst=1 and accept it on the first clock edge after deassertion.

Configuration
REQ-028 SHALL, with GATE_CHK_FIRST_FAIL_EN defined, add outputs first_fail_ab (2) and first_fail_y (7) that capture {a,b} and y of the first mismatching sample in a run, plus first_fail_vld (1); all three clear on start and reset.
REQ-029 SHALL, without GATE_CHK_FIRST_FAIL_EN, omit these ports and their registers; all other behaviour is identical.

Structure
REQ-030 SHALL take state encodings (IDLE=2'd0, CHECK=2'd1, DONE=2'd2) and the gate bit-index constants from shared include file gate_chk_defs.vh.
REQ-031 SHALL instantiate one combinational sub-module, gate_ref_model (inputs a, b; output expected[6:0]), as the golden model.

Verification
REQ-032 Start, then four correct samples ab=00,01,10,11 -> done=1, pass=1, err_count=0, err_mask=0, coverage=4'hF.
REQ-033 Start, then four samples with y[2] (not) inverted at ab=10 -> err_count=1, err_mask=7'b0000100, pass=0; with macro, first_fail_ab=2'b10.
REQ-034 Start, then samples ab=00,00,01,01, all correct -> done=1, coverage=4'b0011, pass=0.
REQ-035 Start and sample_valid together, then four correct samples -> the coincident sample is not counted; done after the 4th following sample.
REQ-036 Assert rst after two samples -> outputs return to zero immediately; a later start plus four correct samples gives pass=1.
REQ-037 ERR_W=2 with NUM_VECTORS=6, all samples wrong -> err_count saturates at 3, pass=0.

Source files
------------

// File: rtl/gate_response_checker_pkg.sv
// rtl/gate_response_checker_pkg.sv - shared constants for the gate response checker
package gate_response_checker_pkg;

`include "gate_chk_defs.vh"

    typedef logic [NUM_GATES-1:0] gate_vec_t;

endpackage

// File: rtl/gate_chk_defs.vh
// rtl/gate_chk_defs.vh - FSM state encodings and gate bit indices for the gate response checker
`ifndef GATE_CHK_DEFS_VH
`define GATE_CHK_DEFS_VH

localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_CHECK = 2'd1;
localparam logic [1:0] ST_DONE  = 2'd2;

localparam int GATE_AND  = 0;
localparam int GATE_OR   = 1;
localparam int GATE_NOT  = 2;
localparam int GATE_NAND = 3;
localparam int GATE_NOR  = 4;
localparam int GATE_XOR  = 5;
localparam int GATE_XNOR = 6;
localparam int NUM_GATES = 7;

`endif

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational golden model of the seven gates under test
module gate_ref_model
    import gate_response_checker_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [6:0] expected
);

    always_comb begin
        expected            = '0;
        expected[GATE_AND]  = a & b;
        expected[GATE_OR]   = a | b;
        expected[GATE_NOT]  = ~a;
        expected[GATE_NAND] = ~(a & b);
        expected[GATE_NOR]  = ~(a | b);
        expected[GATE_XOR]  = a ^ b;
        expected[GATE_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - checks observed gate outputs against a golden model over a run of samples
// Optional first-failure capture ports are enabled by defining GATE_CHK_FIRST_FAIL_EN.
module gate_response_checker
    import gate_response_checker_pkg::*;
#(
    parameter int NUM_VECTORS = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             a,
    input  logic             b,
    input  logic [6:0]       y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [6:0]       err_mask,
    output logic [3:0]       coverage
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    output logic [1:0]       first_fail_ab,
    output logic [6:0]       first_fail_y,
    output logic             first_fail_vld
`endif
);

    localparam logic [7:0] LAST_CNT = 8'(NUM_VECTORS - 1);

    logic [1:0] state;
    logic [7:0] sample_cnt;
    logic [6:0] expected;
    logic [6:0] diff;
    logic       accept;

    gate_ref_model u_ref (
        .a        (a),
        .b        (b),
        .expected (expected)
    );

    // start has priority over a coincident sample, which is simply dropped
    assign accept = sample_valid && (state == ST_CHECK) && !start;
    assign diff   = y ^ expected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            err_count  <= '0;
            err_mask   <= '0;
            coverage   <= '0;
        end else if (start) begin
            state      <= ST_CHECK;
            sample_cnt <= '0;
            err_count  <= '0;
            err_mask   <= '0;
            coverage   <= '0;
        end else if (accept) begin
            sample_cnt       <= sample_cnt + 8'd1;
            err_mask         <= err_mask | diff;
            coverage[{a, b}] <= 1'b1;
            if ((diff != '0) && (err_count != {ERR_W{1'b1}}))
                err_count <= err_count + 1'b1;
            if (sample_cnt == LAST_CNT)
                state <= ST_DONE;
        end
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_fail_ab  <= '0;
            first_fail_y   <= '0;
            first_fail_vld <= 1'b0;
        end else if (start) begin
            first_fail_ab  <= '0;
            first_fail_y   <= '0;
            first_fail_vld <= 1'b0;
        end else if (accept && (diff != '0) && !first_fail_vld) begin
            first_fail_ab  <= {a, b};
            first_fail_y   <= y;
            first_fail_vld <= 1'b1;
        end
    end
`endif

    assign busy = (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0) && (coverage == 4'hF);

endmodule

// File: tb/tb_gate_response_checker.sv
// tb/tb_gate_response_checker.sv - randomized scoreboard bench for gate_response_checker
module tb_gate_response_checker;

    localparam int NV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, sample_valid = 1'b0, a = 1'b0, b = 1'b0;
    logic [6:0] y = '0;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [6:0] err_mask;
    logic [3:0] coverage;

    logic       start2 = 1'b0, v2 = 1'b0, a2 = 1'b0, b2 = 1'b0;
    logic [6:0] y2 = '0;
    logic       busy2, done2, pass2;
    logic [1:0] err2;
    logic [6:0] mask2;
    logic [3:0] cov2;

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [1:0] ff_ab, ff_ab2;
    logic [6:0] ff_y, ff_y2;
    logic       ff_vld, ff_vld2;
`endif

    gate_response_checker #(.NUM_VECTORS(NV), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .a(a), .b(b), .y(y), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .err_mask(err_mask), .coverage(coverage)
`ifdef GATE_CHK_FIRST_FAIL_EN
        , .first_fail_ab(ff_ab), .first_fail_y(ff_y), .first_fail_vld(ff_vld)
`endif
    );

    gate_response_checker #(.NUM_VECTORS(6), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sample_valid(v2),
        .a(a2), .b(b2), .y(y2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .err_mask(mask2), .coverage(cov2)
`ifdef GATE_CHK_FIRST_FAIL_EN
        , .first_fail_ab(ff_ab2), .first_fail_y(ff_y2), .first_fail_vld(ff_vld2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         err;
        logic [6:0] mask;
        logic [3:0] cov;
        logic       pass;
        logic       ffv;
        logic [1:0] ffab;
        logic [6:0] ffy;
    } rec_t;

    rec_t q[$];
    rec_t last;

    int n_cmp = 0;
    int n_fail = 0;

    logic       m_active = 1'b0;
    int         m_err, m_n;
    logic [6:0] m_mask;
    logic [3:0] m_cov;
    logic       m_ffv;
    logic [1:0] m_ffab;
    logic [6:0] m_ffy;
    logic       done_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Truth table of each gate, indexed by {a,b}
    function automatic logic [6:0] exp_y(input logic aa, input logic bb);
        logic [3:0] tt;
        int idx;
        idx = 2 * int'(aa) + int'(bb);
        exp_y = '0;
        for (int g = 0; g < 7; g++) begin
            case (g)
                0: tt = 4'b1000;
                1: tt = 4'b1110;
                2: tt = 4'b0011;
                3: tt = 4'b0111;
                4: tt = 4'b0001;
                5: tt = 4'b0110;
                default: tt = 4'b1001;
            endcase
            exp_y[g] = tt[idx];
        end
    endfunction

    task automatic model_step(input logic st, input logic v, input logic aa,
                              input logic bb, input logic [6:0] yy);
        logic [6:0] d;
        rec_t r;
        if (st) begin
            m_active = 1'b1; m_err = 0; m_n = 0; m_mask = '0; m_cov = '0;
            m_ffv = 1'b0; m_ffab = '0; m_ffy = '0;
        end else if (v && m_active) begin
            d = yy ^ exp_y(aa, bb);
            if (d != '0) begin
                m_err++;
                if (!m_ffv) begin m_ffv = 1'b1; m_ffab = {aa, bb}; m_ffy = yy; end
            end
            m_mask = m_mask | d;
            m_cov[2 * int'(aa) + int'(bb)] = 1'b1;
            m_n++;
            if (m_n == NV) begin
                r.err = (m_err > 255) ? 255 : m_err;
                r.mask = m_mask; r.cov = m_cov;
                r.pass = (m_err == 0) && (m_cov == 4'hF);
                r.ffv = m_ffv; r.ffab = m_ffab; r.ffy = m_ffy;
                q.push_back(r);
                last = r;
                m_active = 1'b0;
            end
        end
    endtask

    task automatic cyc(input logic st, input logic v, input logic aa,
                       input logic bb, input logic [6:0] yy);
        start = st; sample_valid = v; a = aa; b = bb; y = yy;
        @(posedge clk); #1;
        start = 1'b0; sample_valid = 1'b0;
        model_step(st, v, aa, bb, yy);
    endtask

    task automatic good(input logic aa, input logic bb);
        cyc(1'b0, 1'b1, aa, bb, exp_y(aa, bb));
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (!rst) begin
            check("busy", {31'd0, busy}, {31'd0, m_active});
            if (done && !done_q) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    r = q.pop_front();
                    check("pass", {31'd0, pass}, {31'd0, r.pass});
                    check("err_count", {24'd0, err_count}, r.err);
                    check("err_mask", {25'd0, err_mask}, {25'd0, r.mask});
                    check("coverage", {28'd0, coverage}, {28'd0, r.cov});
`ifdef GATE_CHK_FIRST_FAIL_EN
                    check("first_fail_vld", {31'd0, ff_vld}, {31'd0, r.ffv});
                    check("first_fail_ab", {30'd0, ff_ab}, {30'd0, r.ffab});
                    check("first_fail_y", {25'd0, ff_y}, {25'd0, r.ffy});
`endif
                end
            end
        end
        done_q = done;
    end

    initial begin
        logic       aa, bb, v;
        logic [6:0] yy;
        int         t;

        // asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        check("rst_err_mask", {25'd0, err_mask}, 32'd0);
        check("rst_coverage", {28'd0, coverage}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // all four combinations correct
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        good(0, 0); good(0, 1); good(1, 0); good(1, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // not-gate output wrong at ab=10
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        good(0, 0); good(0, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, exp_y(1, 0) ^ 7'b0000100);
        good(1, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // partial coverage
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        good(0, 0); good(0, 0); good(0, 1); good(0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // start coincident with a sample: that sample is dropped
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 7'h7F);
        good(0, 0); good(0, 1); good(1, 0);
        check("coincident_not_done", {31'd0, done}, 32'd0);
        good(1, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // randomized runs with gaps, injected errors and junk samples in DONE
        for (int r = 0; r < 30; r++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 7'($urandom));
            t = 0;
            while (m_active && t < 200) begin
                aa = 1'($urandom); bb = 1'($urandom);
                v  = ($urandom_range(0, 9) < 7);
                yy = exp_y(aa, bb);
                if ($urandom_range(0, 5) == 0) yy = yy ^ (7'd1 << $urandom_range(0, 6));
                cyc(1'b0, v, aa, bb, yy);
                t++;
            end
            check("run_timeout", {31'd0, m_active}, 32'd0);
            cyc(1'b0, 1'b1, 1'($urandom), 1'($urandom), 7'($urandom));
            cyc(1'b0, 1'b1, 1'($urandom), 1'($urandom), 7'($urandom));
            check("hold_done", {31'd0, done}, 32'd1);
            check("hold_err_count", {24'd0, err_count}, last.err);
            check("hold_err_mask", {25'd0, err_mask}, {25'd0, last.mask});
            check("hold_coverage", {28'd0, coverage}, {28'd0, last.cov});
        end

        // reset mid-run, start held during reset, then a clean run
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        good(0, 1); good(1, 0);
        #2 rst = 1'b1;
        #1;
        m_active = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_err_mask", {25'd0, err_mask}, 32'd0);
        check("midrst_coverage", {28'd0, coverage}, 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        check("start_in_rst", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        good(1, 1); good(1, 0); good(0, 1); good(0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("post_rst_pass", {31'd0, pass}, 32'd1);

        // saturating 2-bit counter over six wrong samples
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a2 = 1'($urandom); b2 = 1'($urandom);
            y2 = ~exp_y(a2, b2); v2 = 1'b1;
            @(posedge clk); #1;
            v2 = 1'b0;
        end
        @(negedge clk);
        check("sat_done", {31'd0, done2}, 32'd1);
        check("sat_err_count", {30'd0, err2}, 32'd3);
        check("sat_pass", {31'd0, pass2}, 32'd0);
        check("sat_err_mask", {25'd0, mask2}, 32'h7F);

        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("queue_drain", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
